// File: rtl/led_pattern_sequencer.sv
// led_pattern_sequencer
//   Drives a WIDTH-bit LED/PMOD bus with one of four patterns: rotate left,
//   rotate right, bounce (ping-pong) or binary count. The pattern advances
//   once every period+1 cycles while enabled, or on a manual step_now strobe.
//
//   Optional build macro: SEQ_PDM_DIM_EN
//     When defined, a first-order sigma-delta modulator dims the whole bus.
//     That build adds the brightness input. Duty is brightness / 2^DIM_BITS.
//
// Ports
//   clk30       : system clock (30 MHz on board)
//   rst         : asynchronous active-high reset
//   enable      : 1 = prescaler runs and auto-steps, 0 = prescaler holds
//   mode        : 0 rotate-left, 1 rotate-right, 2 bounce, 3 binary count
//   period      : one auto step every period+1 cycles
//   step_now    : single-cycle manual step request
//   brightness  : PDM duty (SEQ_PDM_DIM_EN builds only)
//   pattern_out : registered pattern, optionally PDM-masked
//   step_strobe : 1-cycle pulse in the first cycle a new pattern is shown
//   wrap        : 1-cycle pulse on the step that completes a full cycle
module led_pattern_sequencer #(
  parameter int WIDTH         = 32,
  parameter int PRESCALE_BITS = 24,
  parameter int DIM_BITS      = 8
) (
  input  logic                     clk30,
  input  logic                     rst,
  input  logic                     enable,
  input  logic [1:0]               mode,
  input  logic [PRESCALE_BITS-1:0] period,
  input  logic                     step_now,
`ifdef SEQ_PDM_DIM_EN
  input  logic [DIM_BITS-1:0]      brightness,
`endif
  output logic [WIDTH-1:0]         pattern_out,
  output logic                     step_strobe,
  output logic                     wrap
);

  typedef enum logic {DIR_UP, DIR_DOWN} dir_t;

  logic [WIDTH-1:0]         pattern;
  logic [WIDTH-1:0]         pattern_nxt;
  dir_t                     dir;
  dir_t                     dir_nxt;
  logic [PRESCALE_BITS-1:0] cnt;
  logic [1:0]               mode_q;
  logic                     tick;
  logic                     mode_chg;
  logic                     step;
  logic                     wrap_nxt;

  // A mode change takes priority over any step in the same cycle: the
  // sequence restarts from bit 0 and the step request is dropped.
  always_comb begin
    tick        = enable && (cnt >= period);
    mode_chg    = (mode != mode_q);
    step        = (tick || step_now) && !mode_chg;
    pattern_nxt = pattern;
    dir_nxt     = dir;
    case (mode_q)
      2'd0: pattern_nxt = {pattern[WIDTH-2:0], pattern[WIDTH-1]};
      2'd1: pattern_nxt = {pattern[0], pattern[WIDTH-1:1]};
      2'd2: begin
        // Direction flips on reaching an end, so each endpoint is shown once.
        if (dir == DIR_UP) begin
          pattern_nxt = pattern << 1;
          if (pattern_nxt[WIDTH-1]) dir_nxt = DIR_DOWN;
        end else begin
          pattern_nxt = pattern >> 1;
          if (pattern_nxt[0]) dir_nxt = DIR_UP;
        end
      end
      default: pattern_nxt = pattern + WIDTH'(1);
    endcase
    wrap_nxt = (mode_q == 2'd3) ? (pattern_nxt == '0) : (pattern_nxt == WIDTH'(1));
  end

  always_ff @(posedge clk30 or posedge rst) begin
    if (rst) begin
      pattern     <= WIDTH'(1);
      dir         <= DIR_UP;
      cnt         <= '0;
      mode_q      <= mode;
      step_strobe <= 1'b0;
      wrap        <= 1'b0;
    end else begin
      step_strobe <= step;
      wrap        <= step && wrap_nxt;
      if (mode_chg) begin
        pattern <= WIDTH'(1);
        dir     <= DIR_UP;
        cnt     <= '0;
        mode_q  <= mode;
      end else begin
        // A manual step also restarts the prescaler period.
        if (tick || step_now) cnt <= '0;
        else if (enable)      cnt <= cnt + PRESCALE_BITS'(1);
        if (step) begin
          pattern <= pattern_nxt;
          dir     <= dir_nxt;
        end
      end
    end
  end

`ifdef SEQ_PDM_DIM_EN
  logic [DIM_BITS-1:0] acc;
  logic [DIM_BITS:0]   acc_sum;
  logic                pdm_bit;

  assign acc_sum = {1'b0, acc} + {1'b0, brightness};

  // The carry out of the accumulator is the PDM bit: it is high on
  // brightness out of every 2^DIM_BITS cycles.
  always_ff @(posedge clk30 or posedge rst) begin
    if (rst) begin
      acc     <= '0;
      pdm_bit <= 1'b0;
    end else begin
      acc     <= acc_sum[DIM_BITS-1:0];
      pdm_bit <= acc_sum[DIM_BITS];
    end
  end

  assign pattern_out = pattern & {WIDTH{pdm_bit}};
`else
  logic unused_dim_cfg;
  assign unused_dim_cfg = ^DIM_BITS;
  assign pattern_out    = pattern;
`endif

endmodule
